// File: rtl/sdram_client_pkg.sv
// Shared definitions for SDRAM client blocks (read-side line fetcher today,
// write-back client later).
//   - fetch_state_e   : client FSM state encoding
//   - ADDR_W / DATA_W : controller port widths
//   - MAX_BURST_WORDS : longest burst a client may request (one column range)
//   - addr_bank/addr_row/addr_col : byte-address field extraction
//     (bank 2 | row 11 | column 8 | byte 2)
package sdram_client_pkg;

  localparam int ADDR_W          = 23;
  localparam int DATA_W          = 32;
  localparam int MAX_BURST_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_RECEIVE,
    ST_DONE,
    ST_ERROR
  } fetch_state_e;

  function automatic logic [1:0] addr_bank(input logic [ADDR_W-1:0] a);
    return a[22:21];
  endfunction

  function automatic logic [10:0] addr_row(input logic [ADDR_W-1:0] a);
    return a[20:10];
  endfunction

  function automatic logic [7:0] addr_col(input logic [ADDR_W-1:0] a);
    return a[9:2];
  endfunction

endpackage

// File: rtl/sdram_line_fetcher_line_buffer.sv
// line_buffer_pingpong: two banks of BUFFER_DEPTH x DATA_WIDTH words in one
// simple dual-port RAM.
//   clk, rst_n          : clock, synchronous active-low reset (read register only)
//   wr_en/wr_bank/wr_index/wr_data : write port
//   rd_bank/rd_index    : read address, sampled every edge
//   rd_data             : registered read data, old contents on a same-address write
module line_buffer_pingpong #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 256,
  localparam int IDX_W       = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_bank,
  input  logic [IDX_W-1:0]      rd_index,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2*BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank, wr_index}] <= wr_data;
  end

  // Non-blocking update of mem_q makes a colliding read see the old word.
  always_comb rd_data_d = mem_q[{rd_bank, rd_index}];

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sdram_line_fetcher.sv
// sdram_line_fetcher: issues one burst read per fetch request to the SDRAM
// controller read port, stores the returned words into the back bank of a
// ping-pong line buffer, and serves the front bank to the video pipeline.
//   clk, rst_n                    : clock, synchronous active-low reset
//   fetch_start/address/words     : fetch request (length clamped to 256)
//   fetch_busy/done/error         : fetch status (done/error are 1-cycle pulses)
//   swap, front_bank              : bank exchange control and current front bank
//   line_index, line_data         : front-bank read port, 1-cycle latency
//   mem_rd_*                      : SDRAM controller read port
module sdram_line_fetcher
  import sdram_client_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int BUFFER_DEPTH   = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(BUFFER_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_start,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  input  logic [8:0]               fetch_words,
  output logic                     fetch_busy,
  output logic                     fetch_done,
  output logic                     fetch_error,
  input  logic                     swap,
  output logic                     front_bank,
  input  logic [IDX_W-1:0]         line_index,
  output logic [DATA_WIDTH-1:0]    line_data,
  output logic                     mem_rd_request,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_address,
  output logic [8:0]               mem_rd_burst_length,
  input  logic                     mem_rd_available,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]               len_q, len_d;
  logic [8:0]               count_q, count_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     target_q, target_d;
  logic                     front_q, front_d;
  logic                     busy_q, busy_d;
  logic [8:0]               clamp_len;
  logic                     wr_en;

  assign clamp_len = (fetch_words > 9'(MAX_BURST_WORDS)) ? 9'(MAX_BURST_WORDS) : fetch_words;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      wd_q     <= '0;
      target_q <= 1'b1;
      front_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      count_q  <= count_d;
      wd_q     <= wd_d;
      target_q <= target_d;
      front_q  <= front_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    count_d  = count_q;
    wd_d     = wd_q;
    target_d = target_q;
    front_d  = front_q ^ swap;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          addr_d   = fetch_address & ~ADDRESS_WIDTH'(3);
          len_d    = clamp_len;
          target_d = ~front_q;
          state_d  = (clamp_len == 9'd0) ? ST_DONE : ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        count_d = '0;
        wd_d    = '0;
        state_d = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        if (mem_rd_available) begin
          wr_en   = 1'b1;
          count_d = count_q + 9'd1;
          wd_d    = '0;
          if (count_q == len_q - 9'd1) state_d = ST_DONE;
        end else if (wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERROR;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d != ST_IDLE);
  end

  line_buffer_pingpong #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_bank (target_q),
    .wr_index(count_q[IDX_W-1:0]),
    .wr_data (mem_rd_data),
    .rd_bank (front_q),
    .rd_index(line_index),
    .rd_data (line_data)
  );

  assign fetch_busy          = busy_q;
  assign fetch_done          = (state_q == ST_DONE);
  assign fetch_error         = (state_q == ST_ERROR);
  assign mem_rd_request      = (state_q == ST_REQUEST);
  assign mem_rd_address      = addr_q;
  assign mem_rd_burst_length = len_q;
  assign front_bank          = front_q;

endmodule
